// File: rtl/gate_pipe.sv
// gate_pipe: registered NUM_IN-operand bitwise gate unit with a 2-entry valid/ready output FIFO
module gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [NUM_IN*WIDTH-1:0] A,
  input  logic [2:0]              OP,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [WIDTH-1:0]        C,
  output logic                    ERR
);
  logic [1:0]     count_q, count_d;
  logic [WIDTH:0] e0_q, e0_d, e1_q, e1_d, new_e;
  logic [WIDTH-1:0] and_v, or_v, xor_v, res;
  logic push, pop, wr0;
  assign IN_READY  = (count_q < 2'd2) && !RST;
  assign OUT_VALID = count_q != 2'd0;
  assign C         = OUT_VALID ? e0_q[WIDTH:1] : '0;
  assign ERR       = OUT_VALID & e0_q[0];
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;
  // Reduce all operand words, then select the function; entry is {result, err}
  always_comb begin
    and_v = '1;
    or_v  = '0;
    xor_v = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_v = and_v & A[k*WIDTH +: WIDTH];
      or_v  = or_v  | A[k*WIDTH +: WIDTH];
      xor_v = xor_v ^ A[k*WIDTH +: WIDTH];
    end
    res = OP == 3'd0 ? and_v  :
          OP == 3'd1 ? ~and_v :
          OP == 3'd2 ? or_v   :
          OP == 3'd3 ? ~or_v  :
          OP == 3'd4 ? xor_v  :
          OP == 3'd5 ? ~xor_v :
          OP == 3'd6 ? A[WIDTH-1:0] : '0;
    new_e = {res, OP == 3'd7};
  end
  // FIFO update: e0 is always the head; pop shifts e1 down, push fills the first free slot
  always_comb begin
    wr0     = push && (count_q == 2'd0 || (count_q == 2'd1 && pop));
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    e0_d    = (pop && count_q == 2'd2) ? e1_q : wr0 ? new_e : e0_q;
    e1_d    = (push && count_q == 2'd1 && !pop) ? new_e : e1_q;
  end
  // State registers; reset discards all buffered entries
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end
endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: table vectors, hand sequences and randomized scoreboard checks for gate_pipe
module tb_gate_pipe;
  logic        CLK, RST;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, ERR;
  logic [15:0] A;
  logic [2:0]  OP;
  logic [7:0]  C;
  logic        v2, r2, ov2, or2, err2;
  logic [11:0] a2;
  logic [2:0]  op2;
  logic [3:0]  c2;
  int checks = 0, errors = 0;
  logic [8:0] q[$];
  bit last_acc;

  gate_pipe #(.WIDTH(8), .NUM_IN(2)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .OP(OP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .C(C), .ERR(ERR));

  gate_pipe #(.WIDTH(4), .NUM_IN(3)) dut2 (
    .CLK(CLK), .RST(RST), .IN_VALID(v2), .IN_READY(r2), .A(a2), .OP(op2),
    .OUT_VALID(ov2), .OUT_READY(or2), .C(c2), .ERR(err2));

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // Reference: per bit, count how many words hold a 1 and apply the gate's definition
  function automatic logic [8:0] ref_m(input logic [15:0] a, input logic [2:0] op);
    logic [7:0] r;
    int ones;
    for (int b = 0; b < 8; b++) begin
      ones = int'(a[b]) + int'(a[8+b]);
      case (op)
        3'd0: r[b] = ones == 2;
        3'd1: r[b] = ones != 2;
        3'd2: r[b] = ones > 0;
        3'd3: r[b] = ones == 0;
        3'd4: r[b] = ones % 2 == 1;
        3'd5: r[b] = ones % 2 == 0;
        3'd6: r[b] = a[b];
        default: r[b] = 1'b0;
      endcase
    end
    return {r, op == 3'd7};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model();
    logic v;
    v = q.size() != 0;
    chk("model_out_valid", 32'(OUT_VALID), 32'(v));
    chk("model_c", 32'(C), v ? 32'(q[0][8:1]) : 0);
    chk("model_err", 32'(ERR), v ? 32'(q[0][0]) : 0);
    chk("model_in_ready", 32'(IN_READY), 32'(q.size() < 2 && !RST));
  endtask

  task automatic step();
    bit acc, pp;
    logic [8:0] e;
    acc = IN_VALID && q.size() < 2 && !RST;
    pp  = q.size() != 0 && OUT_READY;
    e   = ref_m(A, OP);
    @(posedge CLK);
    if (RST) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    last_acc = acc;
    #1;
    chk_model();
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a0, a1, c;
    logic       err;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic [8:0] e;
    tbl[0] = '{3'd0, 8'h0C, 8'h0A, 8'h08, 1'b0};
    tbl[1] = '{3'd1, 8'h0C, 8'h0A, 8'hF7, 1'b0};
    tbl[2] = '{3'd2, 8'h0C, 8'h0A, 8'h0E, 1'b0};
    tbl[3] = '{3'd3, 8'h0C, 8'h0A, 8'hF1, 1'b0};
    tbl[4] = '{3'd4, 8'h0C, 8'h0A, 8'h06, 1'b0};
    tbl[5] = '{3'd5, 8'h0C, 8'h0A, 8'hF9, 1'b0};
    tbl[6] = '{3'd6, 8'h0C, 8'h0A, 8'h0C, 1'b0};
    tbl[7] = '{3'd7, 8'h5A, 8'h33, 8'h00, 1'b1};
    tbl[8] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    RST = 1; IN_VALID = 0; OUT_READY = 0; A = 0; OP = 0;
    v2 = 0; or2 = 1; a2 = 0; op2 = 0;
    #1;
    chk("reset_in_ready", 32'(IN_READY), 0);
    chk("reset_out_valid", 32'(OUT_VALID), 0);
    step();
    step();
    RST = 0;
    #1;
    chk("release_in_ready", 32'(IN_READY), 1);
    // Truth table with the consumer always ready
    OUT_READY = 1;
    foreach (tbl[i]) begin
      IN_VALID = 1; OP = tbl[i].op; A = {tbl[i].a1, tbl[i].a0};
      step();
      chk($sformatf("tbl%0d_c", i), 32'(C), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_err", i), 32'(ERR), 32'(tbl[i].err));
    end
    IN_VALID = 0;
    step();
    chk("drain_out_valid", 32'(OUT_VALID), 0);
    // Backpressure: two entries fill the buffer, third waits for a pop
    OUT_READY = 0; IN_VALID = 1; OP = 3'd1;
    A = {8'h0F, 8'hFF}; step();
    chk("bp_ready1", 32'(IN_READY), 1);
    A = {8'h00, 8'h00}; step();
    chk("bp_ready2", 32'(IN_READY), 0);
    A = {8'hFF, 8'hF0}; step();
    chk("bp_held_ready", 32'(IN_READY), 0);
    chk("bp_head", 32'(C), 32'h F0);
    OUT_READY = 1; step();
    chk("bp_pop1_c", 32'(C), 32'hFF);
    chk("bp_pop1_ready", 32'(IN_READY), 1);
    chk("bp_third_not_yet", 32'(last_acc), 0);
    step();
    chk("bp_third_acc", 32'(last_acc), 1);
    chk("bp_pop2_c", 32'(C), 32'h0F);
    IN_VALID = 0; step();
    chk("bp_empty", 32'(OUT_VALID), 0);
    // Streaming: one result per cycle
    IN_VALID = 1;
    for (int i = 0; i < 16; i++) begin
      OP = 3'(i % 7); A = 16'($urandom);
      e = ref_m(A, OP);
      step();
      chk("stream_c", 32'(C), 32'(e[8:1]));
      chk("stream_ready", 32'(IN_READY), 1);
      chk("stream_acc", 32'(last_acc), 1);
    end
    IN_VALID = 0; step();
    // Randomized traffic against the scoreboard, with a reset mid-stream
    last_acc = 1;
    for (int i = 0; i < 400; i++) begin
      if (!IN_VALID || last_acc) begin
        IN_VALID = 1'($urandom);
        A = 16'($urandom);
        OP = 3'($urandom_range(0, 7));
      end
      OUT_READY = $urandom_range(0, 3) != 0;
      if (i == 200) begin
        IN_VALID = 1; OUT_READY = 0; step(); step();
        RST = 1;
        #1;
        chk("rst_out_valid", 32'(OUT_VALID), 0);
        chk("rst_c", 32'(C), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_in_ready", 32'(IN_READY), 0);
        q.delete();
        step();
        RST = 0;
        #1;
        chk("rst_release_ready", 32'(IN_READY), 1);
        chk("rst_no_old", 32'(OUT_VALID), 0);
      end
      step();
    end
    IN_VALID = 0; OUT_READY = 1;
    step(); step(); step();
    // Wide configuration: words 0xF, 0x5, 0x3
    v2 = 1; a2 = 12'h35F;
    op2 = 3'd4; step();
    chk("wide_xor", 32'(c2), 32'h9);
    op2 = 3'd0; step();
    chk("wide_and", 32'(c2), 32'h1);
    op2 = 3'd3; step();
    chk("wide_nor", 32'(c2), 32'h0);
    chk("wide_err", 32'(err2), 0);
    v2 = 0; step();
    chk("wide_empty", 32'(ov2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
